// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Brief    : Parametrised MIPS data memory with byte/half/word access, handshake,
//            wait states and registered read data. Define DMEM_ERR_EN to enable
//            misalignment, illegal-size and range error reporting.
// Revision : 1.0  initial release
// ============================================================================
module dmem_ctrl #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rd,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_a;
    logic [31:0] r_wd;
    logic [31:0] r_mem [DEPTH];

    logic          w_accept;
    logic          w_commit;
    logic          w_use_in;
    logic          c_we;
    logic [1:0]    c_size;
    logic          c_uns;
    logic [31:0]   c_a;
    logic [31:0]   c_wd;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_lanes;
    logic [31:0]   w_wdata;
    logic          w_err;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic          w_unused;

    assign ready    = reset_n && (r_state != S_WAIT);
    assign w_accept = req && ready;
    assign w_commit = reset_n && ((w_accept && (WAIT == 0)) ||
                                  (r_state == S_WAIT && r_cnt == 4'd1));

    // With no wait states the access commits on its own accept edge, so the
    // live inputs are used; otherwise the fields latched at accept are used.
    assign w_use_in = (r_state != S_WAIT);
    assign c_we     = w_use_in ? we   : r_we;
    assign c_size   = w_use_in ? size : r_size;
    assign c_uns    = w_use_in ? uns  : r_uns;
    assign c_a      = w_use_in ? a    : r_a;
    assign c_wd     = w_use_in ? wd   : r_wd;

    assign w_idx    = c_a[AW+1:2];
    assign w_word   = r_mem[w_idx];
    assign w_half   = c_a[1] ? w_word[31:16] : w_word[15:0];
    assign w_unused = &{1'b0, c_a[31:AW+2]};

    always_comb begin
        w_err   = 1'b0;
        w_lanes = 4'b0000;
        w_wdata = {4{c_wd[7:0]}};
        case (c_size)
            2'b00: w_lanes = 4'b0001 << c_a[1:0];
            2'b01: begin
                w_wdata = {2{c_wd[15:0]}};
                w_lanes = c_a[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = c_wd;
                w_lanes = 4'b1111;
            end
        endcase
`ifdef DMEM_ERR_EN
        if ((c_size == 2'b01 && c_a[0]) ||
            (c_size == 2'b10 && c_a[1:0] != 2'b00) ||
            (c_size == 2'b11) ||
            ({2'b00, c_a[31:2]} >= 32'(DEPTH)))
            w_err = 1'b1;
`endif
    end

    always_comb begin
        w_byte = w_word[7:0];
        case (c_a[1:0])
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            2'b11:   w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
        case (c_size)
            2'b00:   w_load = c_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = c_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            rvalid  <= 1'b0;
            rd      <= 32'd0;
            err     <= 1'b0;
        end else begin
            rvalid <= w_commit;
            err    <= w_commit && w_err;
            rd     <= (w_commit && !c_we && !w_err) ? w_load : 32'd0;
            case (r_state)
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1)
                        r_state <= S_RESP;
                end
                default: begin
                    if (w_accept) begin
                        if (WAIT == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(WAIT);
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we   <= we;
            r_size <= size;
            r_uns  <= uns;
            r_a    <= a;
            r_wd   <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && c_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lanes[i])
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire
